audioport_loader: RTL
=====================

# audioport_loader

APB3 initiator that keeps the audioport sample FIFOs fed. When the audioport raises its interrupt, the loader performs a full refill: it pulls stereo samples from a valid/ready stream and writes each left/right pair into the left and right FIFO registers, then writes CMD_IRQACK. Between refills it forwards single host commands (CMD_START, CMD_STOP, CMD_CLR, ...) as APB writes to the command register. It sits between the sample source and the audioport APB slave port, on the opposite end of the same APB bus.

## Interface
- FIFO_DEPTH, default AUDIO_FIFO_SIZE: number of sample pairs written per refill.
- BASE_ADDR, default 32'h0000_0000: byte address of audioport register index 0.
- clk  in  1  system clock; all logic rises on posedge.
- rst_n  in  1  reset, synchronous, active-low, sampled on posedge clk.
- PSEL / PENABLE / PWRITE  out  1 each  APB3 control.
- PADDR  out  32  BASE_ADDR + 4*register index.
- PWDATA  out  32  write data.
- PRDATA  in  32  unused (write-only initiator).
- PREADY  in  1  slave ready; extends ACCESS while low.
- PSLVERR  in  1  slave error, sampled at transfer completion.
- irq_in  in  1  audioport interrupt (level).
- en_in  in  1  refill enable; when low, irq_in is ignored in IDLE.
- smp_valid  in  1  sample stream valid.
- smp_ready  out  1  sample accepted when smp_valid && smp_ready.
- smp_left / smp_right  in  24 each  sample data.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_code  in  32  command word written to CMD_REG_INDEX.
- busy_out  out  1  high in any state other than IDLE.
- err_out  out  1  sticky; set by PSLVERR=1 at any transfer completion.

## Operation
- States: IDLE, CMD_SETUP, CMD_ACCESS, LOAD, L_SETUP, L_ACCESS, R_SETUP, R_ACCESS, ACK_SETUP, ACK_ACCESS.
- IDLE: cmd_ready=1. If cmd_valid, latch cmd_code and go to CMD_SETUP. Else if en_in && irq_in, clear pair_cnt and go to LOAD. A command wins over a refill in the same cycle.
- CMD_*: write the latched code to CMD_REG_INDEX, then return to IDLE.
- LOAD: smp_ready=1. On smp_valid, latch both channels and go to L_SETUP. Otherwise stay in LOAD; there is no timeout.
- L_*: write {8'h00, left} to LEFT_FIFO_INDEX. Then R_*: write {8'h00, right} to RIGHT_FIFO_INDEX.
- After R_ACCESS completes: if pair_cnt == FIFO_DEPTH-1, go to ACK_SETUP; else increment pair_cnt and go to LOAD.
- ACK_*: write CMD_IRQACK to CMD_REG_INDEX, then go to IDLE.
- cmd_ready is 0 outside IDLE. Commands wait until the refill ends; a refill cannot be interrupted.
- en_in going low mid-refill has no effect; the refill completes.
- PSLVERR does not abort the sequence. It only sets err_out, which clears only on reset.
- pair_cnt width is $clog2(FIFO_DEPTH). It never wraps within a refill.

## Timing
- SETUP cycle: PSEL=1, PENABLE=0, PADDR/PWDATA/PWRITE=1 valid.
- ACCESS cycle: PSEL=1, PENABLE=1, signals held stable. The transfer completes on the first ACCESS cycle with PREADY=1; the FSM advances on that edge.
- Back-to-back transfers: the next SETUP follows immediately and PSEL stays high, e.g. L_ACCESS→R_SETUP.
- In IDLE and LOAD: PSEL=0, PENABLE=0, PWRITE=0. PADDR/PWDATA hold their last value.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Command latency: cmd_valid accepted at edge N → SETUP in cycle N+1 → completion at N+2 with PREADY=1.
- Refill with PREADY=1 and smp_valid=1 throughout:
  - 5 cycles per pair (LOAD + 4 APB cycles), plus 2 cycles for the ACK.
  - FIFO_DEPTH=16: 82 cycles from leaving IDLE to re-entering IDLE.
- irq_in clears on the ACK completion edge, so IDLE sees it low and no double refill occurs.
- Reset (rst_n=0 at an edge):
  - State returns to IDLE; pair_cnt=0; all outputs 0, including PADDR and PWDATA; err_out=0.
  - An in-flight transfer is abandoned and the latched sample is dropped.

## Structure
- audioport_pkg provides the existing AUDIO_FIFO_SIZE, CMD_REG_INDEX, LEFT_FIFO_INDEX, RIGHT_FIFO_INDEX and CMD_* constants.
- Add loader_state_t (enum of the states above) to audioport_pkg.
- One natural sub-module, apb_write_initiator:
  - Inputs: start, addr, data.
  - Generates SETUP/ACCESS and returns done/err.
  - The loader FSM sequences it.

## Test plan
- Reset mid-refill (in R_ACCESS, PREADY=0): at the next edge all outputs are 0 and busy_out=0; a subsequent irq_in starts again from pair 0.
- irq_in=1, en_in=1, PREADY=1, samples left=i, right=0x800000+i, FIFO_DEPTH=16:
  - Exactly 32 FIFO writes alternating addresses BASE+4*LEFT/RIGHT with data 0x00000000+i / 0x00800000+i.
  - Then one write of CMD_IRQACK; 82 cycles total.
- PREADY held low for 3 cycles in L_ACCESS: PSEL/PENABLE/PADDR/PWDATA stay stable for 4 ACCESS cycles, and no sample is lost or duplicated.
- smp_valid low for 5 cycles in LOAD: smp_ready stays 1, PSEL stays 0, and the refill resumes with the correct sample.
- cmd_valid (CMD_START) and irq_in in the same IDLE cycle: the START write completes first, then the refill begins. A cmd_valid during the refill sees cmd_ready=0 until the refill returns to IDLE.
- PSLVERR=1 on the 3rd transfer: err_out=1 from the next cycle and stays high; the remaining writes proceed unchanged.

Source files
------------

// File: rtl/audioport_pkg.sv
// Shared audioport register map, command words and loader state encoding.
package audioport_pkg;

    localparam int unsigned AUDIO_FIFO_SIZE  = 16;

    localparam int unsigned CMD_REG_INDEX    = 0;
    localparam int unsigned LEFT_FIFO_INDEX  = 12;
    localparam int unsigned RIGHT_FIFO_INDEX = 13;

    localparam logic [31:0] CMD_NOP    = 32'h0000_0000;
    localparam logic [31:0] CMD_CLR    = 32'h0000_0001;
    localparam logic [31:0] CMD_CFG    = 32'h0000_0002;
    localparam logic [31:0] CMD_START  = 32'h0000_0004;
    localparam logic [31:0] CMD_STOP   = 32'h0000_0008;
    localparam logic [31:0] CMD_LEVEL  = 32'h0000_0010;
    localparam logic [31:0] CMD_IRQACK = 32'h0000_0020;

    typedef enum logic [3:0] {
        IDLE,
        CMD_SETUP,
        CMD_ACCESS,
        LOAD,
        L_SETUP,
        L_ACCESS,
        R_SETUP,
        R_ACCESS,
        ACK_SETUP,
        ACK_ACCESS
    } loader_state_t;

    // Byte address of a 32-bit register index relative to the block base.
    function automatic logic [31:0] reg_addr(input logic [31:0] base, input int unsigned index);
        return base + 32'(index * 4);
    endfunction

endpackage

// File: rtl/apb_write_initiator.sv
// Single-beat APB3 write master: a start pulse launches SETUP, ACCESS holds until PREADY.
module apb_write_initiator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic        pready,
    input  logic        pslverr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        done_c,
    output logic        err_c
);

    assign done_c = psel && penable && pready;
    assign err_c  = done_c && pslverr;

    // A start on the completion edge chains straight into the next SETUP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else if (start) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b1;
            paddr   <= addr;
            pwdata  <= data;
        end else if (psel && !penable) begin
            penable <= 1'b1;
        end else if (done_c) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
        end
    end

endmodule

// File: rtl/audioport_loader.sv
// APB initiator that refills the audioport sample FIFOs on interrupt and
// forwards host commands to the command register between refills.
module audioport_loader
    import audioport_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = AUDIO_FIFO_SIZE,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic        irq_in,
    input  logic        en_in,
    input  logic        smp_valid,
    output logic        smp_ready,
    input  logic [23:0] smp_left,
    input  logic [23:0] smp_right,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_code,
    output logic        busy_out,
    output logic        err_out
);

    localparam int unsigned CNT_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [31:0] CMD_ADDR   = reg_addr(BASE_ADDR, CMD_REG_INDEX);
    localparam logic [31:0] LEFT_ADDR  = reg_addr(BASE_ADDR, LEFT_FIFO_INDEX);
    localparam logic [31:0] RIGHT_ADDR = reg_addr(BASE_ADDR, RIGHT_FIFO_INDEX);

    loader_state_t    state;
    logic [CNT_W-1:0] pair_cnt;
    logic [23:0]      right_q;
    logic             start_c;
    logic [31:0]      addr_c;
    logic [31:0]      data_c;
    logic             done_c;
    logic             xfer_err_c;
    logic             last_c;
    logic             unused_prdata;

    assign unused_prdata = ^PRDATA;
    assign last_c        = (pair_cnt == LAST_PAIR);

    assign cmd_ready = (state == IDLE);
    assign smp_ready = (state == LOAD);
    assign busy_out  = (state != IDLE);

    // Launch the next write on the edge that enters each SETUP state.
    always_comb begin
        start_c = 1'b0;
        addr_c  = CMD_ADDR;
        data_c  = '0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    start_c = 1'b1;
                    data_c  = cmd_code;
                end
            end
            LOAD: begin
                if (smp_valid) begin
                    start_c = 1'b1;
                    addr_c  = LEFT_ADDR;
                    data_c  = {8'h00, smp_left};
                end
            end
            L_ACCESS: begin
                if (done_c) begin
                    start_c = 1'b1;
                    addr_c  = RIGHT_ADDR;
                    data_c  = {8'h00, right_q};
                end
            end
            R_ACCESS: begin
                if (done_c && last_c) begin
                    start_c = 1'b1;
                    data_c  = CMD_IRQACK;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pair_cnt <= '0;
            right_q  <= '0;
            err_out  <= 1'b0;
        end else begin
            if (xfer_err_c) begin
                err_out <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state <= CMD_SETUP;
                    end else if (en_in && irq_in) begin
                        pair_cnt <= '0;
                        state    <= LOAD;
                    end
                end
                CMD_SETUP:  state <= CMD_ACCESS;
                CMD_ACCESS: if (done_c) state <= IDLE;
                LOAD: begin
                    if (smp_valid) begin
                        right_q <= smp_right;
                        state   <= L_SETUP;
                    end
                end
                L_SETUP:    state <= L_ACCESS;
                L_ACCESS:   if (done_c) state <= R_SETUP;
                R_SETUP:    state <= R_ACCESS;
                R_ACCESS: begin
                    if (done_c) begin
                        if (last_c) begin
                            state <= ACK_SETUP;
                        end else begin
                            pair_cnt <= pair_cnt + CNT_W'(1);
                            state    <= LOAD;
                        end
                    end
                end
                ACK_SETUP:  state <= ACK_ACCESS;
                ACK_ACCESS: if (done_c) state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

    apb_write_initiator u_apb (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_c),
        .addr    (addr_c),
        .data    (data_c),
        .pready  (PREADY),
        .pslverr (PSLVERR),
        .psel    (PSEL),
        .penable (PENABLE),
        .pwrite  (PWRITE),
        .paddr   (PADDR),
        .pwdata  (PWDATA),
        .done_c  (done_c),
        .err_c   (xfer_err_c)
    );

endmodule
